mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- N-master arbiter in front of one shared single-port synchronous memory.
- Generalises the fixed two-way CPU / CPU_ctrl memory mux. Masters are the CPU instruction port, CPU data port, CPU_ctrl, and future DMA/debug masters.
- Provides:
  - round-robin fairness;
  - per-master grant and read-return handshakes;
  - a lock for back-to-back accesses;
  - an exclusive mode that hands the memory to the debug master while the CPU is halted.

Parameters:
- NUM_M, 3, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (1..3).
- PRIO_M, 0, master index that owns memory in exclusive mode.

Ports:
- sys_clk  in  1  clock; all state on rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- excl_en  in  1  exclusive mode: only PRIO_M may be granted.
- m_req  in  NUM_M  per-master access request.
- m_lock  in  NUM_M  hold grant on the next cycle if still requesting.
- m_we  in  NUM_M  1 = write, 0 = read.
- m_addr  in  NUM_M*AW  packed addresses; master i at [i*AW +: AW].
- m_wdata  in  NUM_M*DW  packed write data.
- m_gnt  out  NUM_M  one-hot (or zero) grant; access accepted this cycle.
- m_rvalid  out  NUM_M  one-hot read-data-valid.
- m_rdata  out  DW  shared read data; valid for the master flagged in m_rvalid.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  DW  memory read data, RD_LAT cycles after mem_re.

Behaviour:
- Reset (sys_rst low, asynchronous):
  - rr pointer = 0; lock owner cleared; read-tracking pipeline cleared.
  - m_rvalid = 0, m_gnt = 0.
  - mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
- Grant is combinational from m_req, excl_en, lock state and pointer; at most one bit set.
- Priority order:
  1. excl_en = 1: grant PRIO_M iff m_req[PRIO_M]; all others 0. Pointer and lock frozen.
  2. Else lock owner L valid and m_req[L] = 1: grant L.
  3. Else first requester at or after the pointer, wrapping NUM_M-1 -> 0.
- On a grant to master g (non-lock case): pointer <= (g+1) mod NUM_M at the clock edge.
- Locked re-grants do not advance the pointer.
- Lock state:
  - set to g when m_gnt[g] & m_lock[g];
  - cleared when the owner is not granted, drops m_lock, or excl_en rises.
- Memory drive:
  - mem_* mirror the granted master's addr/wdata/we.
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - No grant: mem_we = mem_re = 0; mem_addr/mem_wdata hold master 0 values (don't-care).
- Writes complete in the grant cycle; no response.
- Reads:
  - a RD_LAT-deep shift pipeline carries (valid, id).
  - m_rvalid[id] is asserted exactly RD_LAT cycles after the grant.
  - m_rdata = mem_rdata passthrough.
- Back-to-back reads from different masters return in grant order, one per cycle.
- Reads in flight complete even if excl_en changes.
- Asynchronous reset mid-read drops all pending rvalid.
- Masters must hold req/addr/wdata/we stable until m_gnt; no request is dropped or duplicated.
- NUM_M = 1 degenerates to a pass-through that grants whenever requested.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs stat_gnt_cnt (NUM_M*32) and stat_wait_cnt (NUM_M*32).
  - stat_gnt_cnt[i]++ on each m_gnt[i].
  - stat_wait_cnt[i]++ on each cycle with m_req[i] & ~m_gnt[i].
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counter logic are absent; functional behaviour is identical.

Decomposition:
- Package pdu_arb_pkg holds:
  - MAX_M = 8;
  - IDW = $clog2(MAX_M) id width;
  - onehot-to-index function;
  - packed-slice helper functions.
- One sub-module, arb_rr_pick: combinational rotate–priority-encode–unrotate.
  - Inputs: req, ptr.
  - Outputs: onehot gnt, idx, any.

Test Plan:
- Reset: all outputs 0. Release reset, m_req = 3'b111, all reads → grants 0, 1, 2, 0 on successive cycles. m_rvalid follows each grant by RD_LAT = 1, with mem_rdata routed correctly.
- Lock: master 1 holds m_lock with m_req = 3'b111 for 4 cycles → m_gnt = 3'b010 ×4. Drop lock → next grant goes to master 2.
- Exclusive: excl_en = 1, m_req = 3'b110, PRIO_M = 0 → m_gnt = 0 and mem_re = 0. Then assert m_req[0] → m_gnt = 3'b001.
- Mixed traffic:
  - master 0 writes 0xDEADBEEF to 0x40 while master 2 requests a read of 0x40;
  - the write is granted first, mem_we = 1 for one cycle;
  - the read is granted the next cycle and returns 0xDEADBEEF.
- Latency and reset: with RD_LAT = 3, issue reads from masters 2, 0, 1 back-to-back → m_rvalid order 2, 0, 1 at grant+3. Assert sys_rst mid-flight → m_rvalid = 0 immediately, no later stray rvalid.
- ARB_PERF_CNT_EN: run a 10-cycle contention test → stat counters for each master equal the counted grants and waits; force 2^32 wait cycles via a preset → counter saturates.

Source files
------------

// File: rtl/pdu_arb_pkg.sv
// ---------------------------------------------------------------------------
// pdu_arb_pkg
// Shared constants and helpers for the round-robin memory arbiter.
//   MAX_M        : largest master count the arbiter supports
//   IDW          : width of a master index / id field
//   onehotToIdx  : one-hot grant vector -> master index
//   sliceLsb     : lsb position of master <idx> inside a packed bus
//   wrapNext     : index increment that wraps at n
// ---------------------------------------------------------------------------
package pdu_arb_pkg;

  localparam int MAX_M = 8;
  localparam int IDW   = $clog2(MAX_M);

  // OR-reduction encoder; the result is only meaningful for one-hot or zero input
  function automatic logic [IDW-1:0] onehotToIdx(input logic [MAX_M-1:0] oh);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (oh[i]) idx = idx | IDW'(i);
    end
    return idx;
  endfunction

  function automatic int sliceLsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic logic [IDW-1:0] wrapNext(input logic [IDW-1:0] idx, input int n);
    logic [IDW-1:0] nxt;
    if (int'(idx) >= n - 1) nxt = '0;
    else                    nxt = idx + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
// Combinational round-robin picker: rotate the request vector so the
// pointer position becomes bit 0, priority-encode the lowest set bit,
// then rotate the winner back to its real master index.
//   req [N-1:0]   : request vector
//   ptr [IDW-1:0] : highest-priority master this cycle (must be < N)
//   gnt [N-1:0]   : one-hot winner (zero when nothing requested)
//   idx [IDW-1:0] : winner index
//   any           : at least one request present
// ---------------------------------------------------------------------------
module arb_rr_pick
  import pdu_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic           w_found;

  // Rotated bit k holds the request of master (ptr + k) mod N
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (j == (int'(ptr) + k) % N) w_rot[k] = req[j];
      end
    end
  end

  // Scan downwards so the lowest rotated position wins
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IDW'(k);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    idx = IDW'((int'(ptr) + int'(w_off)) % N);
    any = w_found;
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      gnt[k] = w_found && (idx == IDW'(k));
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
// Round-robin arbiter for NUM_M masters sharing one single-port synchronous
// memory, with per-master lock and a debug-exclusive mode.
// Ports:
//   sys_clk, sys_rst (async, active-low)
//   excl_en                 : only PRIO_M may be granted
//   m_req/m_lock/m_we       : per-master request, lock, write flag
//   m_addr/m_wdata          : packed per-master address / write data
//   m_gnt                   : one-hot grant (combinational)
//   m_rvalid/m_rdata        : read return, RD_LAT cycles after the grant
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata : memory side
// Optional build macro ARB_PERF_CNT_EN adds stat_gnt_cnt / stat_wait_cnt,
// one saturating 32-bit counter per master each.
// ---------------------------------------------------------------------------
module mem_arbiter_rr
  import pdu_arb_pkg::*;
#(
  parameter int NUM_M  = 3,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int PRIO_M = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                excl_en,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_lock,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_gnt,
  output logic [NUM_M-1:0]    m_rvalid,
  output logic [DW-1:0]       m_rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
`ifdef ARB_PERF_CNT_EN
  input  logic [DW-1:0]       mem_rdata,
  output logic [NUM_M*32-1:0] stat_gnt_cnt,
  output logic [NUM_M*32-1:0] stat_wait_cnt
`else
  input  logic [DW-1:0]       mem_rdata
`endif
);

  logic [IDW-1:0]   r_ptr;
  logic             r_lockValid;
  logic [IDW-1:0]   r_lockOwner;
  logic [RD_LAT-1:0] r_pipeValid;
  logic [IDW-1:0]   r_pipeId [RD_LAT];

  logic [NUM_M-1:0] w_pickGnt;
  logic [IDW-1:0]   w_pickIdx;
  logic             w_pickAny;
  logic [NUM_M-1:0] w_gntRaw;
  logic [NUM_M-1:0] w_gnt;
  logic             w_lockHit;
  logic [IDW-1:0]   w_gntIdx;
  logic             w_any;
  logic             w_isWrite;
  logic             w_gntLocked;

  arb_rr_pick #(.N(NUM_M)) u_pick (
    .req (m_req),
    .ptr (r_ptr),
    .gnt (w_pickGnt),
    .idx (w_pickIdx),
    .any (w_pickAny)
  );

  // Grant priority: exclusive mode, then a live lock owner, then round-robin
  always_comb begin
    w_gntRaw  = '0;
    w_lockHit = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (r_lockValid && (r_lockOwner == IDW'(k)) && m_req[k]) w_lockHit = 1'b1;
    end
    if (excl_en) begin
      w_gntRaw[PRIO_M] = m_req[PRIO_M];
    end else if (w_lockHit) begin
      for (int k = 0; k < NUM_M; k++) begin
        w_gntRaw[k] = (r_lockOwner == IDW'(k));
      end
    end else if (w_pickAny) begin
      w_gntRaw = w_pickGnt;
    end
  end

  // Grants are forced low while reset is held, so nothing reaches the memory
  always_comb begin
    w_gnt       = w_gntRaw & {NUM_M{sys_rst}};
    w_any       = |w_gnt;
    w_gntIdx    = onehotToIdx(MAX_M'(w_gnt));
    w_isWrite   = |(w_gnt & m_we);
    w_gntLocked = |(w_gnt & m_lock);
    m_gnt       = w_gnt;
    mem_we      = w_any & w_isWrite;
    mem_re      = w_any & ~w_isWrite;
    m_rdata     = mem_rdata;
  end

  // Without a grant w_gntIdx is 0, so the memory sees master 0's bus
  always_comb begin
    if (sys_rst) begin
      mem_addr  = m_addr[sliceLsb(int'(w_gntIdx), AW) +: AW];
      mem_wdata = m_wdata[sliceLsb(int'(w_gntIdx), DW) +: DW];
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Pointer moves only on fresh grants; exclusive mode freezes it and drops any lock
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ptr       <= '0;
      r_lockValid <= 1'b0;
      r_lockOwner <= '0;
    end else if (excl_en) begin
      r_lockValid <= 1'b0;
    end else begin
      if (w_any && !w_lockHit) r_ptr <= wrapNext(w_gntIdx, NUM_M);
      r_lockValid <= w_gntLocked;
      if (w_gntLocked) r_lockOwner <= w_gntIdx;
    end
  end

  // Read-return pipeline: one stage per cycle of memory latency
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pipeValid <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pipeId[k] <= '0;
    end else begin
      r_pipeValid[0] <= mem_re;
      r_pipeId[0]    <= w_gntIdx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipeValid[k] <= r_pipeValid[k-1];
        r_pipeId[k]    <= r_pipeId[k-1];
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    for (int k = 0; k < NUM_M; k++) begin
      m_rvalid[k] = r_pipeValid[RD_LAT-1] && (r_pipeId[RD_LAT-1] == IDW'(k));
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_gntCnt  [NUM_M];
  logic [31:0] r_waitCnt [NUM_M];

  // Saturating statistics: grants taken and cycles spent waiting, per master
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int k = 0; k < NUM_M; k++) begin
        r_gntCnt[k]  <= '0;
        r_waitCnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        if (w_gnt[k] && (r_gntCnt[k] != 32'hFFFF_FFFF)) r_gntCnt[k] <= r_gntCnt[k] + 32'd1;
        if (m_req[k] && !w_gnt[k] && (r_waitCnt[k] != 32'hFFFF_FFFF))
          r_waitCnt[k] <= r_waitCnt[k] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_M; k++) begin
      stat_gnt_cnt[k*32 +: 32]  = r_gntCnt[k];
      stat_wait_cnt[k*32 +: 32] = r_waitCnt[k];
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rr
// Directed bench for mem_arbiter_rr: one instance with RD_LAT = 1 driven from
// a vector table, and one with RD_LAT = 3 for return ordering and a
// mid-flight reset. Each instance has a small behavioural memory attached.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT = 1 instance
  logic             rst1N;
  logic             excl1;
  logic [NM-1:0]    req1, lock1, we1;
  logic [NM*AW-1:0] addr1;
  logic [NM*DW-1:0] wdata1;
  logic [NM-1:0]    gnt1, rvalid1;
  logic [DW-1:0]    rdata1, memWdata1, memRdata1;
  logic [AW-1:0]    memAddr1;
  logic             memWe1, memRe1;

  // RD_LAT = 3 instance
  logic             rst3N;
  logic             excl3;
  logic [NM-1:0]    req3, lock3, we3;
  logic [NM*AW-1:0] addr3;
  logic [NM*DW-1:0] wdata3;
  logic [NM-1:0]    gnt3, rvalid3;
  logic [DW-1:0]    rdata3, memWdata3, memRdata3;
  logic [AW-1:0]    memAddr3;
  logic             memWe3, memRe3;

  mem_arbiter_rr #(.NUM_M(NM), .AW(AW), .DW(DW), .RD_LAT(1), .PRIO_M(0)) dut1 (
    .sys_clk(clk), .sys_rst(rst1N), .excl_en(excl1),
    .m_req(req1), .m_lock(lock1), .m_we(we1), .m_addr(addr1), .m_wdata(wdata1),
    .m_gnt(gnt1), .m_rvalid(rvalid1), .m_rdata(rdata1),
    .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_we(memWe1), .mem_re(memRe1),
    .mem_rdata(memRdata1)
  );

  mem_arbiter_rr #(.NUM_M(NM), .AW(AW), .DW(DW), .RD_LAT(3), .PRIO_M(0)) dut3 (
    .sys_clk(clk), .sys_rst(rst3N), .excl_en(excl3),
    .m_req(req3), .m_lock(lock3), .m_we(we3), .m_addr(addr3), .m_wdata(wdata3),
    .m_gnt(gnt3), .m_rvalid(rvalid3), .m_rdata(rdata3),
    .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_we(memWe3), .mem_re(memRe3),
    .mem_rdata(memRdata3)
  );

  // Unwritten words read back as A000_0000 | word index
  function automatic logic [31:0] pattern(input logic [31:0] a);
    return 32'hA000_0000 | {24'h0, a[9:2]};
  endfunction

  // Memory behind dut1: one-cycle registered read, write-tracking array
  logic [31:0] mem1 [256];
  logic        mem1Written [256];
  always @(posedge clk) begin
    if (!rst1N) begin
      for (int i = 0; i < 256; i++) mem1Written[i] <= 1'b0;
      memRdata1 <= 32'h0;
    end else begin
      if (memWe1) begin
        mem1[memAddr1[9:2]]        <= memWdata1;
        mem1Written[memAddr1[9:2]] <= 1'b1;
      end
      if (memRe1) begin
        memRdata1 <= mem1Written[memAddr1[9:2]] ? mem1[memAddr1[9:2]] : pattern(memAddr1);
      end
    end
  end

  // Memory behind dut3: read-only pattern with three cycles of latency
  logic [31:0] p0, p1;
  always @(posedge clk) begin
    p0        <= memRe3 ? pattern(memAddr3) : 32'h0;
    p1        <= p0;
    memRdata3 <= p1;
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  we;
    logic        excl;
    logic [31:0] addr0;
    logic [31:0] addr2;
    logic [31:0] wdata0;
    logic [2:0]  expGnt;
    logic        expRe;
    logic        expWe;
    logic [2:0]  expRvalid;
    logic [31:0] expRdata;
    logic [31:0] expMemAddr;
  } vec_t;

  function automatic vec_t mkVec(
    input logic [2:0] req, input logic [2:0] lock, input logic [2:0] we, input logic excl,
    input logic [31:0] addr0, input logic [31:0] addr2, input logic [31:0] wdata0,
    input logic [2:0] expGnt, input logic expRe, input logic expWe,
    input logic [2:0] expRvalid, input logic [31:0] expRdata, input logic [31:0] expMemAddr);
    vec_t v;
    v.req = req; v.lock = lock; v.we = we; v.excl = excl;
    v.addr0 = addr0; v.addr2 = addr2; v.wdata0 = wdata0;
    v.expGnt = expGnt; v.expRe = expRe; v.expWe = expWe;
    v.expRvalid = expRvalid; v.expRdata = expRdata; v.expMemAddr = expMemAddr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req1   = v.req;
    lock1  = v.lock;
    we1    = v.we;
    excl1  = v.excl;
    addr1  = {v.addr2, 32'h0000_0104, v.addr0};
    wdata1 = {32'h0000_2222, 32'h0000_1111, v.wdata0};
  endtask

  vec_t vecs [15];

  logic [2:0]  seqReq    [10];
  logic [2:0]  seqGnt    [10];
  logic [2:0]  seqRvalid [10];
  logic [31:0] seqRdata  [10];

  initial begin
    // Round-robin sweep, lock hold/release, exclusive mode, write-then-read
    vecs[0]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b001, 1'b1, 1'b0, 3'b000, 32'h0,          32'h100);
    vecs[1]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b010, 1'b1, 1'b0, 3'b001, 32'hA000_0040, 32'h104);
    vecs[2]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b100, 1'b1, 1'b0, 3'b010, 32'hA000_0041, 32'h108);
    vecs[3]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b001, 1'b1, 1'b0, 3'b100, 32'hA000_0042, 32'h100);
    vecs[4]  = mkVec(3'b111, 3'b010, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b010, 1'b1, 1'b0, 3'b001, 32'hA000_0040, 32'h104);
    vecs[5]  = mkVec(3'b111, 3'b010, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b010, 1'b1, 1'b0, 3'b010, 32'hA000_0041, 32'h104);
    vecs[6]  = mkVec(3'b111, 3'b010, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b010, 1'b1, 1'b0, 3'b010, 32'hA000_0041, 32'h104);
    vecs[7]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b010, 1'b1, 1'b0, 3'b010, 32'hA000_0041, 32'h104);
    vecs[8]  = mkVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b100, 1'b1, 1'b0, 3'b010, 32'hA000_0041, 32'h108);
    vecs[9]  = mkVec(3'b110, 3'b000, 3'b000, 1'b1, 32'h100, 32'h108, 32'h0, 3'b000, 1'b0, 1'b0, 3'b100, 32'hA000_0042, 32'h0);
    vecs[10] = mkVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h100, 32'h108, 32'h0, 3'b001, 1'b1, 1'b0, 3'b000, 32'h0,          32'h100);
    vecs[11] = mkVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b000, 1'b0, 1'b0, 3'b001, 32'hA000_0040, 32'h0);
    vecs[12] = mkVec(3'b101, 3'b000, 3'b001, 1'b0, 32'h040, 32'h040, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 3'b000, 32'h0,   32'h040);
    vecs[13] = mkVec(3'b100, 3'b000, 3'b000, 1'b0, 32'h100, 32'h040, 32'h0, 3'b100, 1'b1, 1'b0, 3'b000, 32'h0,          32'h040);
    vecs[14] = mkVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h100, 32'h108, 32'h0, 3'b000, 1'b0, 1'b0, 3'b100, 32'hDEAD_BEEF,  32'h0);

    // RD_LAT = 3: reads from masters 2, 0, 1 back-to-back, then two more reads
    seqReq    = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000};
    seqGnt    = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000};
    seqRvalid = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001};
    seqRdata  = '{32'h0, 32'h0, 32'h0, 32'hA000_0042, 32'hA000_0040, 32'hA000_0041,
                  32'h0, 32'h0, 32'h0, 32'hA000_0040};

    // Reset held with requests pending: nothing may leak out
    rst1N  = 1'b0;
    rst3N  = 1'b0;
    excl1  = 1'b0;
    req1   = 3'b111;
    lock1  = '0;
    we1    = 3'b001;
    addr1  = {32'h108, 32'h104, 32'h100};
    wdata1 = {32'h2222, 32'h1111, 32'h5555};
    excl3  = 1'b0;
    req3   = '0;
    lock3  = '0;
    we3    = '0;
    addr3  = {32'h108, 32'h104, 32'h100};
    wdata3 = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset gnt",       32'(gnt1),      32'h0);
    checkOutput("reset rvalid",    32'(rvalid1),   32'h0);
    checkOutput("reset mem_we",    32'(memWe1),    32'h0);
    checkOutput("reset mem_re",    32'(memRe1),    32'h0);
    checkOutput("reset mem_addr",  memAddr1,       32'h0);
    checkOutput("reset mem_wdata", memWdata1,      32'h0);
    checkOutput("reset3 rvalid",   32'(rvalid3),   32'h0);

    @(negedge clk);
    rst1N = 1'b1;
    rst3N = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d gnt", i),    32'(gnt1),    32'(vecs[i].expGnt));
      checkOutput($sformatf("v%0d mem_re", i), 32'(memRe1),  32'(vecs[i].expRe));
      checkOutput($sformatf("v%0d mem_we", i), 32'(memWe1),  32'(vecs[i].expWe));
      checkOutput($sformatf("v%0d rvalid", i), 32'(rvalid1), 32'(vecs[i].expRvalid));
      if (vecs[i].expRvalid != 3'b000)
        checkOutput($sformatf("v%0d rdata", i), rdata1, vecs[i].expRdata);
      if (vecs[i].expGnt != 3'b000)
        checkOutput($sformatf("v%0d mem_addr", i), memAddr1, vecs[i].expMemAddr);
      if (vecs[i].expWe)
        checkOutput($sformatf("v%0d mem_wdata", i), memWdata1, vecs[i].wdata0);
      @(negedge clk);
    end
    req1 = '0;

    for (int i = 0; i < 10; i++) begin
      req3 = seqReq[i];
      #1;
      checkOutput($sformatf("lat3 t%0d gnt", i),    32'(gnt3),    32'(seqGnt[i]));
      checkOutput($sformatf("lat3 t%0d rvalid", i), 32'(rvalid3), 32'(seqRvalid[i]));
      if (seqRvalid[i] != 3'b000)
        checkOutput($sformatf("lat3 t%0d rdata", i), rdata3, seqRdata[i]);
      if (i < 9) @(negedge clk);
    end

    // Read from master 1 is still in flight; reset must kill it at once
    #2;
    rst3N = 1'b0;
    #1;
    checkOutput("lat3 reset rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    rst3N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("lat3 post-reset t%0d rvalid", i), 32'(rvalid3), 32'h0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
